// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the shift_ctrl delay-line sequencer.
// The optional SHIFT_CTRL_STATS_EN build uses SHIFT_CTRL_STATS_W for the stall counter.
package shift_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } shift_ctrl_state_t;

   localparam int SHIFT_CTRL_STATS_W = 16;

endpackage

// File: rtl/shift_ctrl_if.sv
// Stream, flush and status bundle for shift_ctrl; the slave modport is the sequencer side.
// Build option SHIFT_CTRL_STATS_EN adds the stall_cycles status word.
interface shift_ctrl_if
   import shift_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CW         = 3
) ();

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  flush_req;
   logic                  flush_done;
   logic                  busy;
   logic [CW-1:0]         count;
`ifdef SHIFT_CTRL_STATS_EN
   logic [SHIFT_CTRL_STATS_W-1:0] stall_cycles;
`endif

   modport slave (
      input  in_valid, in_data, out_ready, flush_req,
      output in_ready, out_valid, out_data, flush_done, busy, count
`ifdef SHIFT_CTRL_STATS_EN
      , output stall_cycles
`endif
   );

   modport master (
      output in_valid, in_data, out_ready, flush_req,
      input  in_ready, out_valid, out_data, flush_done, busy, count
`ifdef SHIFT_CTRL_STATS_EN
      , input stall_cycles
`endif
   );

endinterface

// File: rtl/shift_register.sv
// DEPTH-stage data delay line that advances all stages together on shift.
// Stages clear on reset so the line presents zero data out of reset.
module shift_register #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  shift,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic [DATA_WIDTH-1:0] stage_p [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage_p[i] <= '0;
      end else if (shift) begin
         stage_p[0] <= in_data;
         for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
      end
   end

   assign out_data = stage_p[DEPTH-1];

endmodule

// File: rtl/shift_ctrl.sv
// Valid/ready sequencer around a stallable shift_register delay line, with flush/drain.
// Build option SHIFT_CTRL_STATS_EN adds a saturating 16-bit downstream stall counter.
module shift_ctrl
   import shift_ctrl_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 8,
   parameter int CW         = $clog2(DEPTH + 1)
) (
   input logic         clk,
   input logic         rst,
   shift_ctrl_if.slave bus
);

   logic              shift;
   logic              accept;
   logic              out_hs;
   logic [DEPTH-1:0]  vld_q;
   logic [CW-1:0]     cnt_q;
   logic [CW-1:0]     cnt_nxt;
   logic              flush_done_q;
   shift_ctrl_state_t state_q;

   function automatic logic [DEPTH-1:0] vld_shift(input logic [DEPTH-1:0] v, input logic a);
      logic [DEPTH:0] t;
      t = {v, a};
      return t[DEPTH-1:0];
   endfunction

   // Global stall: the whole line moves only when the last stage can empty.
   assign shift        = ~vld_q[DEPTH-1] | bus.out_ready;
   assign bus.in_ready = shift && (state_q != DRAIN) && !rst;
   assign accept       = bus.in_valid && bus.in_ready;
   assign out_hs       = vld_q[DEPTH-1] && bus.out_ready;

   always_comb begin
      cnt_nxt = cnt_q;
      if (accept && !out_hs)      cnt_nxt = cnt_q + CW'(1);
      else if (!accept && out_hs) cnt_nxt = cnt_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q        <= '0;
         cnt_q        <= '0;
         flush_done_q <= 1'b0;
         state_q      <= IDLE;
      end else begin
         flush_done_q <= 1'b0;
         cnt_q        <= cnt_nxt;
         if (shift) vld_q <= vld_shift(vld_q, accept);
         case (state_q)
            IDLE: begin
               if (bus.flush_req) begin
                  if (accept) state_q <= DRAIN;
                  else        flush_done_q <= 1'b1;
               end else if (accept) begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               // A flush that coincides with the last word leaving has nothing left to drain.
               if (cnt_nxt == '0) begin
                  state_q      <= IDLE;
                  flush_done_q <= bus.flush_req;
               end else if (bus.flush_req) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (cnt_nxt == '0) begin
                  state_q      <= IDLE;
                  flush_done_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.out_valid  = vld_q[DEPTH-1];
   assign bus.count      = cnt_q;
   assign bus.flush_done = flush_done_q;
   assign bus.busy       = (cnt_q != '0) || (state_q == DRAIN);

   shift_register #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_line (
      .clk      (clk),
      .rst      (rst),
      .shift    (shift),
      .in_data  (bus.in_data),
      .out_data (bus.out_data)
   );

`ifdef SHIFT_CTRL_STATS_EN
   logic [SHIFT_CTRL_STATS_W-1:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (vld_q[DEPTH-1] && !bus.out_ready && (stall_q != '1)) begin
         stall_q <= stall_q + SHIFT_CTRL_STATS_W'(1);
      end
   end

   assign bus.stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_shift_ctrl.sv
// Scoreboard bench for shift_ctrl (DEPTH=4, 8-bit); SHIFT_CTRL_STATS_EN enables the stall counter test.
module tb_shift_ctrl;

   localparam int DEPTH = 4;
   localparam int DW    = 8;
   localparam int CW    = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   shift_ctrl_if #(.DATA_WIDTH(DW), .CW(CW)) bus ();

   shift_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int peak   = 0;
   bit lat_chk = 1'b0;
   logic [DW-1:0] exp_q[$];
   int            acc_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pop and compare on every output handshake, record accepted words.
   always @(negedge clk) begin
      logic [DW-1:0] e;
      int c;
      if (rst) begin
         exp_q.delete();
         acc_q.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: got 0x%0h expected no word", bus.out_data);
            end else begin
               e = exp_q.pop_front();
               c = acc_q.pop_front();
               check("out_data", 32'(bus.out_data), 32'(e));
               if (lat_chk) check("latency", 32'(cyc - c), 32'(DEPTH));
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(bus.in_data);
            acc_q.push_back(cyc);
         end
         if (int'(bus.count) > peak) peak = int'(bus.count);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(negedge clk);
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: got in_ready=0 for 0x%0h, required accept", d);
      end
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_empty(input int max);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max) begin
         step();
         n++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      int blocked_bad;
      bus.in_valid  = 1'b1;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      bus.flush_req = 1'b0;
      rst           = 1'b1;

      // Reset held with in_valid high
      repeat (3) begin
         @(negedge clk);
         check("rst_in_ready", 32'(bus.in_ready), 32'd0);
         check("rst_out_valid", 32'(bus.out_valid), 32'd0);
         check("rst_count", 32'(bus.count), 32'd0);
      end
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_flush_done", 32'(bus.flush_done), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
`ifdef SHIFT_CTRL_STATS_EN
      check("rst_stall", 32'(bus.stall_cycles), 32'd0);
`endif
      step();
      bus.in_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Streaming 0x11..0x18
      step();
      lat_chk = 1'b1;
      peak = 0;
      for (int i = 0; i < 8; i++) push(8'(8'h11 + i));
      wait_empty(20);
      lat_chk = 1'b0;
      check("stream_peak", 32'(peak), 32'd4);

      // Backpressure: fill then hold
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'(8'hA0 + i));
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_in_ready", 32'(bus.in_ready), 32'd0);
         check("bp_count", 32'(bus.count), 32'd4);
         check("bp_out_data", 32'(bus.out_data), 32'hA0);
      end
      step();
      bus.out_ready = 1'b1;
      wait_empty(20);
      step();
      check("bp_count_end", 32'(bus.count), 32'd0);
      check("bp_busy_end", 32'(bus.busy), 32'd0);

      // Flush while idle pulses flush_done one cycle later
      bus.flush_req = 1'b1;
      step();
      bus.flush_req = 1'b0;
      @(negedge clk);
      check("idle_flush_done", 32'(bus.flush_done), 32'd1);
      @(negedge clk);
      check("idle_flush_done_low", 32'(bus.flush_done), 32'd0);

      // Accept 0x55 together with flush_req
      step();
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h55;
      bus.flush_req = 1'b1;
      @(negedge clk);
      check("flush_accept", 32'(bus.in_ready), 32'd1);
      step();
      bus.in_valid  = 1'b0;
      bus.flush_req = 1'b0;
      @(negedge clk);
      check("drain_in_ready", 32'(bus.in_ready), 32'd0);
      check("drain_busy", 32'(bus.busy), 32'd1);
      check("drain_count", 32'(bus.count), 32'd1);
      pulses = 0;
      blocked_bad = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus.flush_done) begin
            pulses++;
            check("flush_done_count", 32'(bus.count), 32'd0);
         end else if (pulses == 0 && bus.in_ready) begin
            blocked_bad++;
         end
      end
      check("flush_pulses", 32'(pulses), 32'd1);
      check("drain_blocked", 32'(blocked_bad), 32'd0);
      check("flush_idle_busy", 32'(bus.busy), 32'd0);
      check("flush_delivered", 32'(exp_q.size()), 32'd0);

      // Reset in the middle of a drain
      step();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) push(8'(8'hC0 + i));
      bus.flush_req = 1'b1;
      step();
      bus.flush_req = 1'b0;
      @(negedge clk);
      check("mid_count", 32'(bus.count), 32'd3);
      check("mid_busy", 32'(bus.busy), 32'd1);
      check("mid_in_ready", 32'(bus.in_ready), 32'd0);
      check("mid_out_valid", 32'(bus.out_valid), 32'd1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("mrst_count", 32'(bus.count), 32'd0);
      check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("mrst_busy", 32'(bus.busy), 32'd0);
      check("mrst_out_data", 32'(bus.out_data), 32'd0);
`ifdef SHIFT_CTRL_STATS_EN
      check("mrst_stall", 32'(bus.stall_cycles), 32'd0);
`endif
      repeat (4) begin
         check("mrst_flush_done", 32'(bus.flush_done), 32'd0);
         @(negedge clk);
      end
      step();
      bus.out_ready = 1'b1;

`ifdef SHIFT_CTRL_STATS_EN
      // Ten stall cycles with a word waiting at the output
      bus.out_ready = 1'b0;
      push(8'h77);
      begin
         int n;
         n = 0;
         @(negedge clk);
         while (!bus.out_valid && n < 10) begin
            @(negedge clk);
            n++;
         end
         check("stats_out_valid", 32'(bus.out_valid), 32'd1);
      end
      check("stats_start", 32'(bus.stall_cycles), 32'd0);
      repeat (10) @(negedge clk);
      check("stats_ten", 32'(bus.stall_cycles), 32'd10);
      bus.out_ready = 1'b1;
      wait_empty(10);
`endif

      step();
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_ctrl.md
# shift_ctrl

Flow-controlled sequencer for a `DEPTH`-stage, `DATA_WIDTH`-bit `shift_register` delay line. It turns the bare `shift` strobe into a valid/ready stream:
- accepts words from an upstream producer;
- tracks which stages hold real data, using a valid-bit shadow;
- stalls the whole line under downstream backpressure;
- on request, drains the line and reports completion.

It sits between stream stages in the SC datapath, wherever a fixed-latency, stallable delay is needed.

## Interface
Parameters:
- `DEPTH`, default 4: number of stages; must be ≥1.
- `DATA_WIDTH`, default 8: word width.
- `CW`, default `$clog2(DEPTH+1)`: width of the occupancy count.

Ports:
- `clk` in, 1: single clock; all logic on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `in_valid` in, 1: upstream word available.
- `in_ready` out, 1: word accepted this cycle when `in_valid && in_ready`.
- `in_data` in, `DATA_WIDTH`: upstream word.
- `out_valid` out, 1: valid bit of the last stage.
- `out_ready` in, 1: downstream accepts.
- `out_data` out, `DATA_WIDTH`: contents of the last stage.
- `flush_req` in, 1: single-cycle request to drain the line.
- `flush_done` out, 1: one-cycle pulse when the drain is complete.
- `busy` out, 1: high when `count != 0` or state is DRAIN.
- `count` out, `CW`: number of valid words in the line.

## Operation
- Shift enable: `shift = ~out_valid | out_ready`. It is a global stall; every stage advances together or none does.
- Shadow register `vld[DEPTH-1:0]` moves with the data.
  - On shift, `vld[0]` is loaded with the accept flag and `vld[i]` with `vld[i-1]`.
  - When `in_valid` is low, a bubble (`vld=0`) enters and the data stage still shifts.
- `out_valid` = `vld[DEPTH-1]`.
- `in_ready = shift && state != DRAIN && !rst`.
- `count` update each cycle:
  - +1 on an input handshake only;
  - −1 on an output handshake only;
  - unchanged when both or neither occur.
  - `count` never exceeds `DEPTH` and never goes below 0.
- State machine, encoded with `shift_ctrl_state_t`:
  - IDLE (`count==0`) → RUN on an input handshake.
  - RUN → IDLE when `count` reaches 0.
  - RUN → DRAIN on `flush_req`.
  - IDLE + `flush_req` → IDLE, with `flush_done` pulsed the next cycle.
  - DRAIN: inputs are blocked and bubbles shift in whenever `shift=1`. When `count` reaches 0 → IDLE and `flush_done=1` for exactly one cycle.
- Boundary behaviour:
  - `flush_req` and an input handshake in the same cycle: the word is accepted first, then DRAIN is entered.
  - `flush_req` while in DRAIN is ignored.
  - Full line (`count==DEPTH`) with `out_ready=0`: `shift=0` and `in_ready=0`; all data is held.
  - Reset mid-DRAIN: goes to IDLE with no `flush_done`; all `vld` bits are cleared.
  - `DEPTH=1`: `out_valid` follows the accept flag after one edge.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `count=0`, `busy=0`, `flush_done=0`, state IDLE, `in_ready=0` while `rst` is high.
- Latency: a word accepted at edge t appears on `out_data` with `out_valid=1` after edge t+DEPTH−1, i.e. `DEPTH` edges counting the accept edge, provided there are no stalls. Each stall cycle adds 1.
- Throughput: 1 word/cycle while `out_ready=1`.
- `in_ready` is combinational from `out_ready` and `out_valid`; this is the only comb in→out path.
- `flush_done` is registered: it rises on the edge on which `count` becomes 0 in DRAIN.

## Configuration
- Macro `SHIFT_CTRL_STATS_EN`.
- Defined: adds output `stall_cycles` (out, 16 bits). It increments on each cycle with `out_valid && !out_ready`, saturates at 0xFFFF, and clears on `rst`.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `shift_ctrl_pkg`:
  - `shift_ctrl_state_t` enum (IDLE, RUN, DRAIN);
  - stats width constant `SHIFT_CTRL_STATS_W = 16`.
- One sub-module instance, `shift_register` (`DEPTH`, `DATA_WIDTH`), driven by `shift`, `in_data`, `rst`.
- The valid shadow, counter and FSM are local to `shift_ctrl`.

## Test plan
- Reset: hold `rst` 3 cycles, with `in_valid=1` → `in_ready=0`, `out_valid=0`, `count=0`; after release, `in_ready=1`.
- Streaming, `DEPTH=4`, `out_ready=1`: push 0x11..0x18 back-to-back → 0x11 appears 4 edges after its accept, one word per cycle in order; `count` peaks at 4.
- Backpressure: fill with 0xA0..0xA3, then `out_ready=0` for 5 cycles → `in_ready=0`, `count=4`, `out_data=0xA0` held; release → 0xA0..0xA3 drain in order.
- Flush: accept 0x55 and raise `flush_req` in the same cycle → 0x55 is delivered, `in_ready=0` during DRAIN, one `flush_done` pulse when `count=0`, then IDLE.
- Reset mid-drain: enter DRAIN with `count=3`, assert `rst` → `count=0`, `out_valid=0`, no `flush_done`.
- With `SHIFT_CTRL_STATS_EN` defined: hold `out_ready=0` with `out_valid=1` for 10 cycles → `stall_cycles=10`.
